// File: rtl/io_serial_peer.sv
// Host-side endpoint of the AGC IO UART link: serializes channel updates onto tx
// and deserializes AGC channel-write frames arriving on rx (3-byte 8N1 frames).
module io_serial_peer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int TIMEOUT_CLKS = 320
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    output logic        tx,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [4:0]  upd_sel,
    input  logic [14:0] upd_data,
    output logic        wr_valid,
    output logic [4:0]  wr_sel,
    output logic [14:0] wr_data,
    output logic        frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uartState_e;

    function automatic logic [7:0] pickByte(input logic [23:0] frame, input logic [1:0] idx);
        case (idx)
            2'd0:    pickByte = frame[23:16];
            2'd1:    pickByte = frame[15:8];
            default: pickByte = frame[7:0];
        endcase
    endfunction

    uartState_e  txState_q, txState_d;
    logic [CW-1:0] txCnt_q, txCnt_d;
    logic [2:0]  txBit_q, txBit_d;
    logic [1:0]  txByte_q, txByte_d;
    logic [23:0] txFrame_q, txFrame_d;
    logic        tx_q, tx_d;
    logic [7:0]  txCurByte;
    logic        updAccept;

    assign upd_ready = (txState_q == S_IDLE) && !reset;
    assign updAccept = upd_valid && upd_ready;
    assign tx        = tx_q;

    // tx is registered from the next-state values so the line never glitches
    always_comb begin
        txState_d = txState_q;
        txCnt_d   = txCnt_q;
        txBit_d   = txBit_q;
        txByte_d  = txByte_q;
        txFrame_d = txFrame_q;
        tx_d      = 1'b1;
        case (txState_q)
            S_IDLE: begin
                if (updAccept) begin
                    txFrame_d = {3'b101, upd_sel, 1'b0, upd_data};
                    txState_d = S_START;
                    txCnt_d   = '0;
                    txBit_d   = '0;
                    txByte_d  = '0;
                end
            end
            default: begin
                if (txCnt_q == BIT_LAST) begin
                    txCnt_d = '0;
                    case (txState_q)
                        S_START: begin
                            txState_d = S_DATA;
                            txBit_d   = '0;
                        end
                        S_DATA: begin
                            if (txBit_q == 3'd7) txState_d = S_STOP;
                            else                 txBit_d   = txBit_q + 3'd1;
                        end
                        S_STOP: begin
                            if (txByte_q == 2'd2) begin
                                txState_d = S_IDLE;
                                txByte_d  = '0;
                            end else begin
                                txState_d = S_START;
                                txByte_d  = txByte_q + 2'd1;
                            end
                        end
                        default: txState_d = S_IDLE;
                    endcase
                end else begin
                    txCnt_d = txCnt_q + CW'(1);
                end
            end
        endcase
        txCurByte = pickByte(txFrame_d, txByte_d);
        case (txState_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = txCurByte[txBit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            txState_q <= S_IDLE;
            txCnt_q   <= '0;
            txBit_q   <= '0;
            txByte_q  <= '0;
            txFrame_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            txState_q <= txState_d;
            txCnt_q   <= txCnt_d;
            txBit_q   <= txBit_d;
            txByte_q  <= txByte_d;
            txFrame_q <= txFrame_d;
            tx_q      <= tx_d;
        end
    end

    logic        rxMeta_q, rxSync_q, rxPrev_q;
    uartState_e  rxState_q, rxState_d;
    logic [CW-1:0] rxCnt_q, rxCnt_d;
    logic [2:0]  rxBit_q, rxBit_d;
    logic [7:0]  rxShift_q, rxShift_d;
    logic [1:0]  rxIdx_q, rxIdx_d;
    logic [4:0]  rxSel_q, rxSel_d;
    logic [6:0]  rxHi_q, rxHi_d;
    logic [TW-1:0] idleCnt_q, idleCnt_d;
    logic        wrValid_q, wrValid_d;
    logic [4:0]  wrSel_q, wrSel_d;
    logic [14:0] wrData_q, wrData_d;
    logic        frameErr_q, frameErr_d;

    assign wr_valid  = wrValid_q;
    assign wr_sel    = wrSel_q;
    assign wr_data   = wrData_q;
    assign frame_err = frameErr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    // Header checks run as each byte completes so a bad byte resyncs immediately
    always_comb begin
        rxState_d  = rxState_q;
        rxCnt_d    = rxCnt_q;
        rxBit_d    = rxBit_q;
        rxShift_d  = rxShift_q;
        rxIdx_d    = rxIdx_q;
        rxSel_d    = rxSel_q;
        rxHi_d     = rxHi_q;
        idleCnt_d  = idleCnt_q;
        wrSel_d    = wrSel_q;
        wrData_d   = wrData_q;
        wrValid_d  = 1'b0;
        frameErr_d = 1'b0;
        case (rxState_q)
            S_IDLE: begin
                if (rxPrev_q && !rxSync_q) begin
                    rxState_d = S_START;
                    rxCnt_d   = '0;
                    idleCnt_d = '0;
                end else if (rxIdx_q != 2'd0) begin
                    if (idleCnt_q == TO_LAST) begin
                        frameErr_d = 1'b1;
                        rxIdx_d    = '0;
                        idleCnt_d  = '0;
                    end else begin
                        idleCnt_d = idleCnt_q + TW'(1);
                    end
                end
            end
            S_START: begin
                if (rxCnt_q == HALF_LAST) begin
                    rxCnt_d   = '0;
                    rxBit_d   = '0;
                    rxState_d = rxSync_q ? S_IDLE : S_DATA;
                end else begin
                    rxCnt_d = rxCnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (rxCnt_q == BIT_LAST) begin
                    rxCnt_d   = '0;
                    rxShift_d = {rxSync_q, rxShift_q[7:1]};
                    if (rxBit_q == 3'd7) rxState_d = S_STOP;
                    else                 rxBit_d   = rxBit_q + 3'd1;
                end else begin
                    rxCnt_d = rxCnt_q + CW'(1);
                end
            end
            default: begin
                if (rxCnt_q == BIT_LAST) begin
                    rxCnt_d   = '0;
                    rxState_d = S_IDLE;
                    idleCnt_d = '0;
                    if (!rxSync_q) begin
                        frameErr_d = 1'b1;
                        rxIdx_d    = '0;
                    end else begin
                        case (rxIdx_q)
                            2'd0: begin
                                if (rxShift_q[7:5] == 3'b101) begin
                                    rxSel_d = rxShift_q[4:0];
                                    rxIdx_d = 2'd1;
                                end else begin
                                    frameErr_d = 1'b1;
                                end
                            end
                            2'd1: begin
                                if (rxShift_q[7]) begin
                                    frameErr_d = 1'b1;
                                    rxIdx_d    = '0;
                                end else begin
                                    rxHi_d  = rxShift_q[6:0];
                                    rxIdx_d = 2'd2;
                                end
                            end
                            default: begin
                                wrValid_d = 1'b1;
                                wrSel_d   = rxSel_q;
                                wrData_d  = {rxHi_q, rxShift_q};
                                rxIdx_d   = '0;
                            end
                        endcase
                    end
                end else begin
                    rxCnt_d = rxCnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rxState_q  <= S_IDLE;
            rxCnt_q    <= '0;
            rxBit_q    <= '0;
            rxShift_q  <= '0;
            rxIdx_q    <= '0;
            rxSel_q    <= '0;
            rxHi_q     <= '0;
            idleCnt_q  <= '0;
            wrValid_q  <= 1'b0;
            wrSel_q    <= '0;
            wrData_q   <= '0;
            frameErr_q <= 1'b0;
        end else begin
            rxState_q  <= rxState_d;
            rxCnt_q    <= rxCnt_d;
            rxBit_q    <= rxBit_d;
            rxShift_q  <= rxShift_d;
            rxIdx_q    <= rxIdx_d;
            rxSel_q    <= rxSel_d;
            rxHi_q     <= rxHi_d;
            idleCnt_q  <= idleCnt_d;
            wrValid_q  <= wrValid_d;
            wrSel_q    <= wrSel_d;
            wrData_q   <= wrData_d;
            frameErr_q <= frameErr_d;
        end
    end

endmodule

// File: tb/tb_io_serial_peer.sv
// Self-checking bench for io_serial_peer: table-driven tx frames with loopback,
// hand-written rx corner cases, and a randomized rx byte stream against a byte-level model.
module tb_io_serial_peer;

    localparam int CPB        = 4;
    localparam int TMO        = 80;
    localparam int FRAME_CLKS = 30 * CPB;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx;
    logic        tx;
    logic        upd_valid;
    logic        upd_ready;
    logic [4:0]  upd_sel;
    logic [14:0] upd_data;
    logic        wr_valid;
    logic [4:0]  wr_sel;
    logic [14:0] wr_data;
    logic        frame_err;

    logic loopMode;
    logic rxDrv;

    int compared   = 0;
    int mismatched = 0;
    int wrSeen     = 0;
    int errSeen    = 0;
    int bothSeen   = 0;

    typedef struct {
        logic [4:0]  sel;
        logic [14:0] data;
        logic [7:0]  b0, b1, b2;
    } txVec_t;

    typedef struct {
        logic [7:0] value;
        logic       stopBit;
        int         gap;
    } rxRec_t;

    txVec_t vecs[4];
    rxRec_t rxStim[$];

    assign rx = loopMode ? tx : rxDrv;

    io_serial_peer #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
        .clock(clock), .reset(reset), .rx(rx), .tx(tx),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_sel(upd_sel), .upd_data(upd_data),
        .wr_valid(wr_valid), .wr_sel(wr_sel), .wr_data(wr_data), .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (wr_valid) wrSeen++;
        if (frame_err) errSeen++;
        if (wr_valid && frame_err) bothSeen++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Line image (start, 8 data LSB first, stop) of each byte, byte 0 in the low bits
    function automatic logic [29:0] lineOf(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        return {1'b1, b2, 1'b0, 1'b1, b1, 1'b0, 1'b1, b0, 1'b0};
    endfunction

    function automatic logic [29:0] expectLine(input logic [4:0] sel, input logic [14:0] data);
        return lineOf({3'b101, sel}, {1'b0, data[14:8]}, data[7:0]);
    endfunction

    task automatic waitReady();
        int guard = 0;
        while (!upd_ready && guard < 400) begin
            @(negedge clock);
            guard++;
        end
        if (!upd_ready) checkOutput("readyTimeout", 32'(upd_ready), 32'd1);
    endtask

    task automatic applyStimulus(input logic [4:0] sel, input logic [14:0] data,
                                 output logic [29:0] lineBits, output int readyLow,
                                 output logic readyAfter, output logic firstLow);
        waitReady();
        upd_sel   = sel;
        upd_data  = data;
        upd_valid = 1'b1;
        @(negedge clock);
        upd_valid = 1'b0;
        upd_sel   = 5'($urandom);
        upd_data  = 15'($urandom);
        readyLow  = 0;
        lineBits  = '0;
        readyAfter = 1'b0;
        firstLow  = tx;
        for (int j = 0; j <= FRAME_CLKS; j++) begin
            if (j < FRAME_CLKS) begin
                if (!upd_ready) readyLow++;
                if (j % CPB == CPB / 2) lineBits[j / CPB] = tx;
                @(negedge clock);
            end else begin
                readyAfter = upd_ready;
            end
        end
    endtask

    task automatic txFrameCheck(input logic [4:0] sel, input logic [14:0] data, input logic [29:0] expLine);
        logic [29:0] lineBits;
        int readyLow;
        logic readyAfter, firstLow;
        int wrBase, errBase;
        wrBase  = wrSeen;
        errBase = errSeen;
        applyStimulus(sel, data, lineBits, readyLow, readyAfter, firstLow);
        repeat (10) @(negedge clock);
        checkOutput("txFirstLow", 32'(firstLow), 32'd0);
        checkOutput("txLine", 32'(lineBits), 32'(expLine));
        checkOutput("readyLowCycles", 32'(readyLow), 32'(FRAME_CLKS));
        checkOutput("readyReassert", 32'(readyAfter), 32'd1);
        checkOutput("loopWrCount", 32'(wrSeen - wrBase), 32'd1);
        checkOutput("loopErrCount", 32'(errSeen - errBase), 32'd0);
        checkOutput("loopWrSel", 32'(wr_sel), 32'(sel));
        checkOutput("loopWrData", 32'(wr_data), 32'(data));
    endtask

    task automatic sendRxByte(input logic [7:0] value, input logic stopBit, input int gap);
        logic [9:0] bits;
        bits = {stopBit, value, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rxDrv = bits[b];
            repeat (CPB) @(negedge clock);
        end
        rxDrv = 1'b1;
        repeat (gap) @(negedge clock);
    endtask

    task automatic pushRx(input logic [7:0] value, input logic stopBit, input int gap);
        rxRec_t rec;
        rec.value   = value;
        rec.stopBit = stopBit;
        rec.gap     = gap;
        rxStim.push_back(rec);
    endtask

    task automatic playRx();
        foreach (rxStim[i]) sendRxByte(rxStim[i].value, rxStim[i].stopBit, rxStim[i].gap);
        repeat (5) @(negedge clock);
    endtask

    // Byte-level reference: frame parsing rules applied to the whole byte stream
    task automatic modelRx(output int expErr, output int expWr,
                           output logic [4:0] expSel, output logic [14:0] expData);
        int idx;
        logic [4:0] sel;
        logic [6:0] hi;
        idx = 0; sel = '0; hi = '0;
        expErr = 0; expWr = 0; expSel = '0; expData = '0;
        foreach (rxStim[i]) begin
            if (!rxStim[i].stopBit) begin
                expErr++;
                idx = 0;
            end else if (idx == 0) begin
                if (rxStim[i].value[7:5] == 3'b101) begin
                    sel = rxStim[i].value[4:0];
                    idx = 1;
                end else begin
                    expErr++;
                end
            end else if (idx == 1) begin
                if (rxStim[i].value[7]) begin
                    expErr++;
                    idx = 0;
                end else begin
                    hi  = rxStim[i].value[6:0];
                    idx = 2;
                end
            end else begin
                expWr++;
                expSel  = sel;
                expData = {hi, rxStim[i].value};
                idx = 0;
            end
            if (rxStim[i].gap > TMO && idx != 0) begin
                expErr++;
                idx = 0;
            end
        end
    endtask

    initial begin
        int wrBase, errBase, expErr, expWr, readyHigh;
        logic [4:0] expSel;
        logic [14:0] expData;
        logic txAt121;

        vecs[0] = '{sel: 5'h01, data: 15'h0037, b0: 8'hA1, b1: 8'h00, b2: 8'h37};
        vecs[1] = '{sel: 5'h1F, data: 15'h7ABC, b0: 8'hBF, b1: 8'h7A, b2: 8'hBC};
        vecs[2] = '{sel: 5'h00, data: 15'h0000, b0: 8'hA0, b1: 8'h00, b2: 8'h00};
        vecs[3] = '{sel: 5'h10, data: 15'h4001, b0: 8'hB0, b1: 8'h40, b2: 8'h01};

        reset = 1'b1; loopMode = 1'b1; rxDrv = 1'b1;
        upd_valid = 1'b0; upd_sel = '0; upd_data = '0;
        repeat (3) @(negedge clock);
        checkOutput("resetTx", 32'(tx), 32'd1);
        checkOutput("resetReady", 32'(upd_ready), 32'd0);
        checkOutput("resetWrValid", 32'(wr_valid), 32'd0);
        checkOutput("resetWrSel", 32'(wr_sel), 32'd0);
        checkOutput("resetWrData", 32'(wr_data), 32'd0);
        checkOutput("resetFrameErr", 32'(frame_err), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("readyAfterReset", 32'(upd_ready), 32'd1);

        for (int v = 0; v < 4; v++)
            txFrameCheck(vecs[v].sel, vecs[v].data, lineOf(vecs[v].b0, vecs[v].b1, vecs[v].b2));

        for (int f = 0; f < 6; f++) begin : rndTx
            logic [4:0] s;
            logic [14:0] d;
            s = 5'($urandom);
            d = 15'($urandom);
            txFrameCheck(s, d, expectLine(s, d));
        end

        waitReady();
        wrBase = wrSeen;
        readyHigh = 0;
        txAt121 = 1'b1;
        upd_sel = 5'h0A; upd_data = 15'h1357; upd_valid = 1'b1;
        @(negedge clock);
        for (int j = 0; j < 126; j++) begin
            if (upd_ready) readyHigh++;
            if (j == 121) begin
                txAt121 = tx;
                upd_valid = 1'b0;
            end
            @(negedge clock);
        end
        repeat (130) @(negedge clock);
        checkOutput("b2bReadyHigh", 32'(readyHigh), 32'd1);
        checkOutput("b2bTxStart", 32'(txAt121), 32'd0);
        checkOutput("b2bWrCount", 32'(wrSeen - wrBase), 32'd2);

        loopMode = 1'b0;
        repeat (5) @(negedge clock);

        wrBase = wrSeen; errBase = errSeen;
        rxStim.delete();
        pushRx(8'h41, 1'b1, 0); pushRx(8'h00, 1'b1, 0); pushRx(8'h05, 1'b1, 20);
        playRx();
        checkOutput("badHdrErr", 32'(errSeen > errBase), 32'd1);
        checkOutput("badHdrNoWr", 32'(wrSeen - wrBase), 32'd0);
        wrBase = wrSeen; errBase = errSeen;
        rxStim.delete();
        pushRx(8'hA2, 1'b1, 0); pushRx(8'h01, 1'b1, 0); pushRx(8'h23, 1'b1, 20);
        playRx();
        checkOutput("goodAfterBadWr", 32'(wrSeen - wrBase), 32'd1);
        checkOutput("goodAfterBadSel", 32'(wr_sel), 32'h02);
        checkOutput("goodAfterBadData", 32'(wr_data), 32'h0123);

        wrBase = wrSeen; errBase = errSeen;
        rxStim.delete();
        pushRx(8'hA3, 1'b0, 4);
        playRx();
        checkOutput("stopBitErr", 32'(errSeen - errBase), 32'd1);
        wrBase = wrSeen; errBase = errSeen;
        rxStim.delete();
        pushRx(8'hA3, 1'b1, 0); pushRx(8'h00, 1'b1, 0); pushRx(8'h05, 1'b1, 20);
        playRx();
        checkOutput("afterStopErrWr", 32'(wrSeen - wrBase), 32'd1);
        checkOutput("afterStopErrSel", 32'(wr_sel), 32'h03);
        checkOutput("afterStopErrData", 32'(wr_data), 32'h0005);

        wrBase = wrSeen; errBase = errSeen;
        rxStim.delete();
        pushRx(8'hA4, 1'b1, 0); pushRx(8'h00, 1'b1, 100);
        playRx();
        checkOutput("timeoutErr", 32'(errSeen - errBase), 32'd1);
        checkOutput("timeoutNoWr", 32'(wrSeen - wrBase), 32'd0);
        errBase = errSeen;
        rxDrv = 1'b0;
        repeat (2) @(negedge clock);
        rxDrv = 1'b1;
        repeat (60) @(negedge clock);
        checkOutput("glitchNoErr", 32'(errSeen - errBase), 32'd0);
        checkOutput("glitchWrHold", 32'(wr_data), 32'h0005);

        rxStim.delete();
        for (int f = 0; f < 10; f++) begin : rndRx
            logic [7:0] b [3];
            int corrupt;
            int g;
            b[0] = {3'b101, 5'($urandom)};
            b[1] = {1'b0, 7'($urandom)};
            b[2] = 8'($urandom);
            corrupt = $urandom_range(0, 6);
            if (corrupt == 0) b[0] = 8'($urandom);
            if (corrupt == 1) b[1][7] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                g = (corrupt == 3 && k == 0) ? 150 : $urandom_range(0, 20);
                if (corrupt == 2 && k == 1 && g < 1) g = 1;
                pushRx(b[k], !(corrupt == 2 && k == 1), g);
            end
        end
        rxStim[rxStim.size() - 1].gap = 150;
        wrBase = wrSeen; errBase = errSeen;
        playRx();
        modelRx(expErr, expWr, expSel, expData);
        checkOutput("rndRxErrCount", 32'(errSeen - errBase), 32'(expErr));
        checkOutput("rndRxWrCount", 32'(wrSeen - wrBase), 32'(expWr));
        if (expWr > 0) begin
            checkOutput("rndRxSel", 32'(wr_sel), 32'(expSel));
            checkOutput("rndRxData", 32'(wr_data), 32'(expData));
        end

        loopMode = 1'b1;
        waitReady();
        wrBase = wrSeen; errBase = errSeen;
        upd_sel = 5'h05; upd_data = 15'h1234; upd_valid = 1'b1;
        @(negedge clock);
        upd_valid = 1'b0;
        repeat (50) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midResetTx", 32'(tx), 32'd1);
        checkOutput("midResetReady", 32'(upd_ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("midResetReadyAfter", 32'(upd_ready), 32'd1);
        repeat (150) @(negedge clock);
        checkOutput("midResetNoWr", 32'(wrSeen - wrBase), 32'd0);
        checkOutput("midResetNoErr", 32'(errSeen - errBase), 32'd0);
        checkOutput("midResetTxIdle", 32'(tx), 32'd1);

        checkOutput("wrErrExclusive", 32'(bothSeen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/io_serial_peer.md
IO_SERIAL_PEER -- requirements
Module: io_serial_peer

Host-side endpoint of the AGC IO UART link: serializes channel updates into the AGC rx line; deserializes AGC channel-write frames from the AGC tx line.

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per UART bit (even, >=4).
REQ-002 Parameter TIMEOUT_CLKS, default 320, max idle cycles between bytes of one rx frame.
REQ-003 clock  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx  input  1  serial line from AGC IO tx; asynchronous, idle high.
REQ-006 tx  output  1  serial line to AGC IO rx; idle high.
REQ-007 upd_valid  input  1  channel update request.
REQ-008 upd_ready  output  1  update accepted when upd_valid && upd_ready.
REQ-009 upd_sel  input  5  channel select of update.
REQ-010 upd_data  input  15  channel data of update.
REQ-011 wr_valid  output  1  one-cycle pulse, received AGC channel write.
REQ-012 wr_sel  output  5  channel select of received write.
REQ-013 wr_data  output  15  data of received write.
REQ-014 frame_err  output  1  one-cycle pulse on any dropped rx frame.

Function
REQ-015 Frame SHALL be 3 bytes: B0={3'b101,sel[4:0]}, B1={1'b0,data[14:8]}, B2=data[7:0].
REQ-016 Byte SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each CLKS_PER_BIT cycles.
REQ-017 TX FSM states IDLE, START, DATA, STOP; byte index 0..2 SHALL sequence B0,B1,B2 with no idle gap between bytes.
REQ-018 upd_ready SHALL be 1 only in IDLE outside reset; on accept sel/data SHALL latch and upd_ready drop the next cycle.
REQ-019 tx SHALL go low the first cycle after accept; full frame SHALL last exactly 30*CLKS_PER_BIT cycles.
REQ-020 upd_ready SHALL reassert the cycle after B2 stop bit ends; back-to-back frames SHALL be legal.
REQ-021 upd_sel/upd_data changes after accept SHALL not affect the frame in flight.
REQ-022 rx SHALL pass a 2-flop synchronizer before any use.
REQ-023 RX FSM states IDLE, START, DATA, STOP; falling edge in IDLE SHALL enter START.
REQ-024 START SHALL re-sample at CLKS_PER_BIT/2; if high, return to IDLE with no error (glitch).
REQ-025 Data and stop bits SHALL be sampled at bit centers, CLKS_PER_BIT apart.
REQ-026 Stop bit 0 SHALL pulse frame_err, discard partial frame, reset byte index to 0.
REQ-027 B0 top bits != 3'b101 or B1 bit7 != 0 SHALL pulse frame_err and discard the frame.
REQ-028 Idle gap >TIMEOUT_CLKS between stop of byte n and start of byte n+1 in a frame SHALL pulse frame_err, reset index.
REQ-029 After valid B2, wr_sel/wr_data SHALL update and wr_valid pulse exactly one cycle, the cycle after B2 stop sample.
REQ-030 wr_sel/wr_data SHALL hold until the next valid frame.
REQ-031 TX and RX paths SHALL be fully independent; simultaneous activity SHALL be legal.
REQ-032 frame_err and wr_valid SHALL never assert in the same cycle.

Reset
REQ-033 In reset: tx=1, upd_ready=0, wr_valid=0, wr_sel=0, wr_data=0, frame_err=0, both FSMs IDLE, indices 0.
REQ-034 upd_ready SHALL be 1 the first cycle after reset deasserts.
REQ-035 Reset mid-frame SHALL abort both paths; tx=1 from the next edge; no wr_valid or frame_err for the aborted frame.

Verification (CLKS_PER_BIT=4, TIMEOUT_CLKS=80)
REQ-036 Accept upd_sel=5'h01, upd_data=15'h0037 -> tx bytes 0xA1,0x00,0x37; upd_ready low 120 cycles.
REQ-037 tx looped to rx, update sel=5'h1F data=15'h7ABC -> wr_valid once, wr_sel=5'h1F, wr_data=15'h7ABC.
REQ-038 rx bytes 0x41,0x00,0x05 -> frame_err pulse, no wr_valid; next valid frame 0xA2,0x01,0x23 -> wr_sel=2, wr_data=15'h0123.
REQ-039 rx byte 0xA3 with stop bit 0 -> frame_err; following 0xA3,0x00,0x05 -> wr_valid, data 15'h0005.
REQ-040 rx 0xA4,0x00 then 100 idle cycles -> frame_err; 2-cycle low glitch -> no error.
REQ-041 Reset asserted mid-B1 of tx frame -> tx=1 next cycle; upd_ready=1 cycle after release.
